// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a loaded pattern MSB-first, one bit per
// clock, for a programmable number of frames (or continuously), with an
// optional idle gap between frames. Drives serial bit-sequence detectors.
module seq_pattern_tx #(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned LEN_W    = 5,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned GAP_CYC  = 0,
    parameter bit          IDLE_BIT = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic [CNT_W-1:0]   frames,
    input  logic               abort,
    output logic               ready,
    output logic               busy,
    output logic               out_bit,
    output logic               out_valid,
    output logic               frame_start,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam int unsigned     GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned     GAP_LOAD  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    logic [1:0]         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   frames_q, frames_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic               out_bit_d;
    logic               out_valid_d;
    logic               frame_start_d;
    logic               done_d;
    logic               err_d;
    logic               ready_d;
    logic [MAX_LEN-1:0] sh_v;

    // Next-state and next-output decode; idx_q is the index of the bit on out_bit
    always_comb begin
        state_d       = state_q;
        pat_d         = pat_q;
        len_d         = len_q;
        frames_d      = frames_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        out_bit_d     = IDLE_BIT;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        sh_v          = '0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (pat_len == '0 || pat_len > MAX_LEN_L) begin
                        err_d = 1'b1;
                    end else begin
                        pat_d         = pattern;
                        len_d         = pat_len;
                        frames_d      = frames;
                        idx_d         = pat_len - ONE_L;
                        sh_v          = pattern >> (pat_len - ONE_L);
                        out_valid_d   = 1'b1;
                        frame_start_d = 1'b1;
                        state_d       = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d       = idx_q - ONE_L;
                    sh_v        = pat_q >> (idx_q - ONE_L);
                    out_valid_d = 1'b1;
                end else if (frames_q == CNT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (frames_q != '0) begin
                        frames_d = frames_q - CNT_W'(1);
                    end
                    if (GAP_CYC > 0) begin
                        gap_d   = GAP_W'(GAP_LOAD);
                        state_d = GAP;
                    end else begin
                        idx_d         = len_q - ONE_L;
                        sh_v          = pat_q >> (len_q - ONE_L);
                        out_valid_d   = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end
            end

            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_q == '0) begin
                    idx_d         = len_q - ONE_L;
                    sh_v          = pat_q >> (len_q - ONE_L);
                    out_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                    state_d       = SHIFT;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (out_valid_d) begin
            out_bit_d = sh_v[0];
        end
        ready_d = (state_d == IDLE);
    end

    // State, captured transfer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            frames_q    <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            out_bit     <= IDLE_BIT;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ready       <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            frames_q    <= frames_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            out_bit     <= out_bit_d;
            out_valid   <= out_valid_d;
            frame_start <= frame_start_d;
            done        <= done_d;
            err         <= err_d;
            ready       <= ready_d;
            busy        <= !ready_d;
        end
    end

endmodule
